cv32e40p_clock_domain_ctrl: RTL and testbench
=============================================

# cv32e40p_clock_domain_ctrl

Multi-domain sleep and clock-gating controller: generalises the core's single gated clock into `NUM_DOMAINS` independently gated clock domains (e.g. core pipeline, APU/FPU, debug/trace). Each domain has its own FSM and idle-hysteresis counter. A domain's clock is cut only after `IDLE_CYCLES` consecutive qualifying idle cycles and is restored combinationally on wake. Sits at the core top level, fed by the free-running clock; drives one clock-gate cell per domain and the aggregate `core_sleep_o`.

## Interface
- `NUM_DOMAINS`, 2: number of gated domains, 1..8.
- `IDLE_CYCLES`, 4: consecutive qualifying idle samples before gating, 1..255.
- `ALWAYS_ON_MASK`, '0: `NUM_DOMAINS`-bit mask; set bit = domain never gated after fetch enable.
- `CNT_W`, derived: max(1, $clog2(`IDLE_CYCLES`)); not user-overridable.

Ports:
- `clk_ungated_i` in 1: free-running clock; the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `scan_cg_en_i` in 1: forces all clock gates open; no effect on FSM state.
- `fetch_enable_i` in 1: fetch enable pulse/level.
- `fetch_enable_o` out 1: sticky registered fetch enable.
- `busy_i` in N: domain d still requires its clock.
- `sleep_allow_i` in N: domain d permitted to gate (controller in WAIT_SLEEP, no debug).
- `wake_i` in N: domain d wake request; acts combinationally on the clock enable.
- `clk_gated_o` out N: gated clock per domain.
- `domain_gated_o` out N: registered; 1 when domain d is in GATED.
- `core_sleep_o` out 1: all domains gated and no enable pending.

## Operation
- `fetch_enable_q` <= `fetch_enable_i` | `fetch_enable_q`. It never clears except on reset.
- Per domain d, the idle qualifier is `q = !busy_i[d] && sleep_allow_i[d] && !wake_i[d] && !ALWAYS_ON_MASK[d]`.
- RESET state:
  - goes to RUN when `fetch_enable_q` = 1; `cnt` = 0.
- RUN state:
  - if `q` and `IDLE_CYCLES` = 1, go to GATED;
  - else if `q`, go to IDLE with `cnt` = 1;
  - otherwise stay in RUN.
- IDLE state:
  - if `!q`, go to RUN with `cnt` = 0;
  - else if `cnt` = `IDLE_CYCLES`-1, go to GATED;
  - otherwise `cnt`++.
- GATED state:
  - if `wake_i[d]` or `busy_i[d]`, go to RUN with `cnt` = 0;
  - otherwise stay in GATED;
  - deasserting `sleep_allow_i` does not wake.
- Clock enable: `en[d]` = (RUN or IDLE) or (GATED and (`wake_i[d]` or `busy_i[d]`)).
  - `en[d]` = 0 in RESET.
- `core_sleep_o` = AND over d of (state = GATED), AND NOT OR(`en`).
  - Always 0 if any `ALWAYS_ON_MASK` bit is set.
- `domain_gated_o[d]` = (state_q[d] = GATED).
- Domains are fully independent; there is no cross-domain ordering.

## Timing
- Reset values:
  - all FSMs in RESET, `cnt` = 0;
  - `fetch_enable_o` = 0, `domain_gated_o` = 0, `core_sleep_o` = 0;
  - `clk_gated_o` held low, unless `scan_cg_en_i` = 1.
- Startup: `fetch_enable_i` sampled high at edge k gives `fetch_enable_q` = 1 after edge k and RUN after edge k+1. The first gated edge is k+2.
- Gating latency: the first qualifying sample at edge t gives GATED after edge t+`IDLE_CYCLES`-1. That is the last edge delivered on `clk_gated_o[d]`.
- Wake latency: 0 cycles. `wake_i[d]` high in a GATED cycle delivers the next edge, and the FSM leaves GATED on that edge. `wake_i` must be glitch-free.
- A single non-qualifying sample in IDLE restarts the count fully; there is no partial credit.
- `busy_i` and `wake_i` both high in the same cycle: treated as wake; identical result.
- RUN with `q` in the same cycle `fetch_enable_q` first rises: not possible, because RUN is only entered one cycle later.
- Reset asserted mid-operation (any state, any `cnt`): immediately returns to RESET and all gates close asynchronously via `en` = 0.
- `IDLE_CYCLES` = 1: one qualifying sample gates the domain, matching the legacy single-domain behaviour.

## Structure
- `cv32e40p_pkg` gains `cg_state_e` {CG_RESET, CG_RUN, CG_IDLE, CG_GATED} (2 bits) and the constant `CG_MAX_DOMAINS` = 8.
- Sub-module `cv32e40p_clock_domain_fsm`: one per domain via generate. Holds the state, counter and `en` logic, and is parametrised by `IDLE_CYCLES` and `ALWAYS_ON`.
- One `pulp_clock_gating` cell per domain in the top.
- Under `PULP_FPGA_EMUL`, `clk_gated_o[d]` = `clk_ungated_i`; the FSMs still run.
- The top holds only the sticky fetch-enable register and the `core_sleep_o` reduction.

## Test plan
- Reset release with `fetch_enable_i` low for 20 cycles: no `clk_gated_o` edges; all outputs 0. Then a 1-cycle `fetch_enable_i` pulse: first gated edge exactly 2 cycles later, and `fetch_enable_o` stays 1.
- `NUM_DOMAINS`=2, `IDLE_CYCLES`=4, domain 0 `q` held high: `domain_gated_o` = 01 after the 4th qualifying edge. Domain 1 busy: `core_sleep_o` = 0. Drop domain 1 busy: `core_sleep_o` = 1 four cycles later.
- `IDLE_CYCLES`=4, `busy_i[0]` pulsed high for 1 cycle after 3 qualifying samples: no gating. Gating occurs 4 samples after the pulse.
- GATED domain with 1-cycle `wake_i` pulse: clock edge in the same cycle; `domain_gated_o` drops next cycle; `core_sleep_o` drops combinationally.
- `ALWAYS_ON_MASK`=2'b10: domain 1 never gates despite `q`, and `core_sleep_o` stays 0 throughout.
- `rst_n` asserted while domain is IDLE with `cnt`=2: clock stops immediately. After release, the domain waits for a new `fetch_enable_i`.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared core definitions: clock-domain controller state encoding and limits.
package cv32e40p_pkg;

    localparam int unsigned CG_MAX_DOMAINS = 8;

    typedef enum logic [1:0] {
        CG_RESET = 2'b00,
        CG_RUN   = 2'b01,
        CG_IDLE  = 2'b10,
        CG_GATED = 2'b11
    } cg_state_e;

    // Idle counter width: max(1, clog2(idle_cycles))
    function automatic int unsigned cg_cnt_width(input int unsigned idle_cycles);
        return (idle_cycles <= 2) ? 1 : $clog2(idle_cycles);
    endfunction

endpackage

// File: rtl/cv32e40p_clock_domain_fsm.sv
// Per-domain sleep FSM: idle hysteresis counter and combinational clock enable.
module cv32e40p_clock_domain_fsm
    import cv32e40p_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 4,
    parameter bit          ALWAYS_ON   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic fetch_enable_i,
    input  logic busy_i,
    input  logic sleep_allow_i,
    input  logic wake_i,
    output logic clk_en_c_o,
    output logic gated_o
);

    localparam int unsigned        CNT_W    = cg_cnt_width(IDLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gated_q;
    logic             qual;
    logic             clk_en;

    assign qual = !busy_i && sleep_allow_i && !wake_i && !ALWAYS_ON;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CG_RESET;
            cnt_q   <= '0;
            gated_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gated_q <= (state_d == CG_GATED);
        end
    end

    // Next state and clock enable; wake/busy reopen the gate in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_en  = 1'b0;
        case (state_q)
            CG_RESET: begin
                if (fetch_enable_i) begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end
            end
            CG_RUN: begin
                clk_en = 1'b1;
                if (qual) begin
                    if (IDLE_CYCLES == 1) begin
                        state_d = CG_GATED;
                    end else begin
                        state_d = CG_IDLE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CG_IDLE: begin
                clk_en = 1'b1;
                if (!qual) begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = CG_GATED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CG_GATED: begin
                if (wake_i || busy_i) begin
                    clk_en  = 1'b1;
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CG_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    assign clk_en_c_o = clk_en;
    assign gated_o    = gated_q;

endmodule

// File: rtl/pulp_clock_gating.sv
// Latch-based integrated clock gate; enable is captured while the clock is low.
module pulp_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic clk_en;

    always_latch begin
        if (clk_i == 1'b0) begin
            clk_en = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/cv32e40p_clock_domain_ctrl.sv
// Multi-domain sleep controller: sticky fetch enable, per-domain FSM and clock gate,
// aggregate core sleep indication.
module cv32e40p_clock_domain_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned            NUM_DOMAINS    = 2,
    parameter int unsigned            IDLE_CYCLES    = 4,
    parameter logic [NUM_DOMAINS-1:0] ALWAYS_ON_MASK = '0
) (
    input  logic                   clk_ungated_i,
    input  logic                   rst_n,
    input  logic                   scan_cg_en_i,
    input  logic                   fetch_enable_i,
    output logic                   fetch_enable_o,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] sleep_allow_i,
    input  logic [NUM_DOMAINS-1:0] wake_i,
    output logic [NUM_DOMAINS-1:0] clk_gated_o,
    output logic [NUM_DOMAINS-1:0] domain_gated_o,
    output logic                   core_sleep_o
);

    logic                   fetch_enable_q;
    logic [NUM_DOMAINS-1:0] clk_en;
    logic [NUM_DOMAINS-1:0] gated;

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_enable_q <= 1'b0;
        end else begin
            fetch_enable_q <= fetch_enable_i | fetch_enable_q;
        end
    end

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : gen_domain
        cv32e40p_clock_domain_fsm #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .ALWAYS_ON   (ALWAYS_ON_MASK[d])
        ) u_fsm (
            .clk_i          (clk_ungated_i),
            .rst_n          (rst_n),
            .fetch_enable_i (fetch_enable_q),
            .busy_i         (busy_i[d]),
            .sleep_allow_i  (sleep_allow_i[d]),
            .wake_i         (wake_i[d]),
            .clk_en_c_o     (clk_en[d]),
            .gated_o        (gated[d])
        );

`ifdef PULP_FPGA_EMUL
        assign clk_gated_o[d] = clk_ungated_i;
`else
        pulp_clock_gating u_cg (
            .clk_i     (clk_ungated_i),
            .en_i      (clk_en[d]),
            .test_en_i (scan_cg_en_i),
            .clk_o     (clk_gated_o[d])
        );
`endif
    end

    assign fetch_enable_o = fetch_enable_q;
    assign domain_gated_o = gated;
    // An always-on domain never gates, so the core can never be fully asleep
    assign core_sleep_o   = (ALWAYS_ON_MASK != '0) ? 1'b0 : ((&gated) & ~(|clk_en));

endmodule

// File: tb/tb_cv32e40p_clock_domain_ctrl.sv
// Scenario bench for the multi-domain clock controller (2 domains, 4 idle cycles).
module tb_cv32e40p_clock_domain_ctrl;

    typedef struct packed {
        logic [1:0] gated;
        logic       sleep;
        logic [1:0] edges;
    } exp_t;

    typedef struct packed {
        logic [1:0] busy;
        logic [1:0] allow;
        logic [1:0] wake;
        logic       sleep_c;
        logic [1:0] gated;
        logic       sleep;
        logic [1:0] edges;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n, scan, fe_in;
    logic [1:0] busy, allow, wake;
    logic       fe_out, sleep, ao_fe_out, ao_sleep;
    logic [1:0] cg, gated, ao_cg, ao_gated;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned e0 = 0, e1 = 0, ao_e1 = 0;
    bit          ao_slept = 1'b0;
    exp_t        sb[$];

    cv32e40p_clock_domain_ctrl #(
        .NUM_DOMAINS(2), .IDLE_CYCLES(4), .ALWAYS_ON_MASK(2'b00)
    ) u_dut (
        .clk_ungated_i(clk), .rst_n(rst_n), .scan_cg_en_i(scan),
        .fetch_enable_i(fe_in), .fetch_enable_o(fe_out),
        .busy_i(busy), .sleep_allow_i(allow), .wake_i(wake),
        .clk_gated_o(cg), .domain_gated_o(gated), .core_sleep_o(sleep)
    );

    cv32e40p_clock_domain_ctrl #(
        .NUM_DOMAINS(2), .IDLE_CYCLES(4), .ALWAYS_ON_MASK(2'b10)
    ) u_dut_ao (
        .clk_ungated_i(clk), .rst_n(rst_n), .scan_cg_en_i(scan),
        .fetch_enable_i(fe_in), .fetch_enable_o(ao_fe_out),
        .busy_i(busy), .sleep_allow_i(allow), .wake_i(wake),
        .clk_gated_o(ao_cg), .domain_gated_o(ao_gated), .core_sleep_o(ao_sleep)
    );

    always #5 clk = ~clk;

    always @(posedge cg[0])    e0++;
    always @(posedge cg[1])    e1++;
    always @(posedge ao_cg[1]) ao_e1++;
    always @(posedge ao_sleep) ao_slept = 1'b1;

    function automatic row_t mk(input logic [1:0] b, input logic [1:0] a, input logic [1:0] w,
                                input logic sc, input logic [1:0] g, input logic s,
                                input logic [1:0] e);
        row_t r;
        r.busy = b; r.allow = a; r.wake = w; r.sleep_c = sc;
        r.gated = g; r.sleep = s; r.edges = e;
        return r;
    endfunction

    task automatic test_reset();
        int unsigned b0, b1;
        exp_t ex, ob;
        rst_n = 1'b0; scan = 1'b0; fe_in = 1'b0;
        busy = 2'b00; allow = 2'b00; wake = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b0 = e0; b1 = e1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ((e0 - b0) != 0 || (e1 - b1) != 0) begin
            n_err++;
            $display("FAIL reset_no_edges: got %0d/%0d edges, want 0/0", e0 - b0, e1 - b1);
        end
        n_cmp++;
        if ({fe_out, gated, sleep} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got fe=%b gated=%b sleep=%b, want all 0", fe_out, gated, sleep);
        end
        // One-cycle fetch enable pulse: first gated edge two cycles after it is sampled
        fe_in = 1'b1;
        sb.push_back('{2'b00, 1'b0, 2'b00});
        sb.push_back('{2'b00, 1'b0, 2'b00});
        sb.push_back('{2'b00, 1'b0, 2'b11});
        for (int i = 0; i < 3; i++) begin
            b0 = e0; b1 = e1;
            @(negedge clk);
            fe_in = 1'b0;
            ex = sb.pop_front();
            ob.gated = gated; ob.sleep = sleep;
            ob.edges = {1'((e1 - b1) != 0), 1'((e0 - b0) != 0)};
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL startup cycle %0d: got gated=%b sleep=%b edges=%b, want gated=%b sleep=%b edges=%b",
                         i, ob.gated, ob.sleep, ob.edges, ex.gated, ex.sleep, ex.edges);
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (fe_out !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_enable_sticky: got %b want 1", fe_out);
        end
    endtask

    task automatic test_gating();
        row_t rows[$];
        rows.push_back(mk(2'b10, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b11));
        rows.push_back(mk(2'b10, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b11));
        rows.push_back(mk(2'b10, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b11));
        rows.push_back(mk(2'b10, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 2'b11));
        rows.push_back(mk(2'b10, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 2'b10));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 2'b10));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 2'b10));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 2'b10));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b11, 1'b1, 2'b10));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b1, 2'b00));
        foreach (rows[i]) begin
            int unsigned b0, b1;
            exp_t ex, ob;
            busy = rows[i].busy; allow = rows[i].allow; wake = rows[i].wake;
            #1;
            n_cmp++;
            if (sleep !== rows[i].sleep_c) begin
                n_err++;
                $display("FAIL gating row %0d sleep_now: got %b want %b", i, sleep, rows[i].sleep_c);
            end
            sb.push_back('{rows[i].gated, rows[i].sleep, rows[i].edges});
            b0 = e0; b1 = e1;
            @(negedge clk);
            ex = sb.pop_front();
            ob.gated = gated; ob.sleep = sleep;
            ob.edges = {1'((e1 - b1) != 0), 1'((e0 - b0) != 0)};
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL gating row %0d: got gated=%b sleep=%b edges=%b, want gated=%b sleep=%b edges=%b",
                         i, ob.gated, ob.sleep, ob.edges, ex.gated, ex.sleep, ex.edges);
            end
        end
    endtask

    task automatic test_wake();
        row_t rows[$];
        rows.push_back(mk(2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 1'b1, 2'b00));
        rows.push_back(mk(2'b00, 2'b11, 2'b01, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b11, 1'b1, 2'b01));
        rows.push_back(mk(2'b01, 2'b11, 2'b01, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b11, 1'b1, 2'b01));
        foreach (rows[i]) begin
            int unsigned b0, b1;
            exp_t ex, ob;
            busy = rows[i].busy; allow = rows[i].allow; wake = rows[i].wake;
            #1;
            n_cmp++;
            if (sleep !== rows[i].sleep_c) begin
                n_err++;
                $display("FAIL wake row %0d sleep_now: got %b want %b", i, sleep, rows[i].sleep_c);
            end
            sb.push_back('{rows[i].gated, rows[i].sleep, rows[i].edges});
            b0 = e0; b1 = e1;
            @(negedge clk);
            ex = sb.pop_front();
            ob.gated = gated; ob.sleep = sleep;
            ob.edges = {1'((e1 - b1) != 0), 1'((e0 - b0) != 0)};
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL wake row %0d: got gated=%b sleep=%b edges=%b, want gated=%b sleep=%b edges=%b",
                         i, ob.gated, ob.sleep, ob.edges, ex.gated, ex.sleep, ex.edges);
            end
        end
    endtask

    task automatic test_hysteresis();
        row_t rows[$];
        rows.push_back(mk(2'b01, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b01, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b0, 2'b11, 1'b1, 2'b01));
        rows.push_back(mk(2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b1, 2'b00));
        foreach (rows[i]) begin
            int unsigned b0, b1;
            exp_t ex, ob;
            busy = rows[i].busy; allow = rows[i].allow; wake = rows[i].wake;
            #1;
            n_cmp++;
            if (sleep !== rows[i].sleep_c) begin
                n_err++;
                $display("FAIL hyst row %0d sleep_now: got %b want %b", i, sleep, rows[i].sleep_c);
            end
            sb.push_back('{rows[i].gated, rows[i].sleep, rows[i].edges});
            b0 = e0; b1 = e1;
            @(negedge clk);
            ex = sb.pop_front();
            ob.gated = gated; ob.sleep = sleep;
            ob.edges = {1'((e1 - b1) != 0), 1'((e0 - b0) != 0)};
            n_cmp++;
            if (ob !== ex) begin
                n_err++;
                $display("FAIL hyst row %0d: got gated=%b sleep=%b edges=%b, want gated=%b sleep=%b edges=%b",
                         i, ob.gated, ob.sleep, ob.edges, ex.gated, ex.sleep, ex.edges);
            end
        end
    endtask

    task automatic test_always_on();
        int unsigned b;
        busy = 2'b00; allow = 2'b11; wake = 2'b00;
        b = ao_e1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (ao_gated !== 2'b01) begin
            n_err++;
            $display("FAIL always_on_gated: got %b want 01", ao_gated);
        end
        n_cmp++;
        if ((ao_e1 - b) != 6) begin
            n_err++;
            $display("FAIL always_on_edges: got %0d want 6", ao_e1 - b);
        end
        n_cmp++;
        if (ao_sleep !== 1'b0 || ao_slept) begin
            n_err++;
            $display("FAIL always_on_sleep: got now=%b ever=%b want 0/0", ao_sleep, ao_slept);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned b0, b1;
        busy = 2'b01; allow = 2'b11; wake = 2'b00;
        @(negedge clk);
        busy = 2'b00;
        repeat (2) @(negedge clk);
        // Domain 0 now IDLE with a count of 2
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({fe_out, gated, sleep} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_outputs: got fe=%b gated=%b sleep=%b, want all 0", fe_out, gated, sleep);
        end
        b0 = e0; b1 = e1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ((e0 - b0) != 0 || (e1 - b1) != 0) begin
            n_err++;
            $display("FAIL midreset_clock_stop: got %0d/%0d edges want 0/0", e0 - b0, e1 - b1);
        end
        scan = 1'b1;
        b0 = e0; b1 = e1;
        repeat (2) @(negedge clk);
        scan = 1'b0;
        n_cmp++;
        if ((e0 - b0) != 2 || (e1 - b1) != 2) begin
            n_err++;
            $display("FAIL scan_open: got %0d/%0d edges want 2/2", e0 - b0, e1 - b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        b0 = e0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ((e0 - b0) != 0 || gated !== 2'b00 || fe_out !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_wait: got edges=%0d gated=%b fe=%b want 0/00/0", e0 - b0, gated, fe_out);
        end
        fe_in = 1'b1;
        b0 = e0;
        @(negedge clk);
        fe_in = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ((e0 - b0) != 0) begin
            n_err++;
            $display("FAIL restart_early: got %0d edges want 0", e0 - b0);
        end
        @(negedge clk);
        n_cmp++;
        if ((e0 - b0) != 1) begin
            n_err++;
            $display("FAIL restart_first_edge: got %0d edges want 1", e0 - b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_gating();
        test_wake();
        test_hysteresis();
        test_always_on();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
